// File: rtl/tpsram_fifo_ctrl.sv
// FIFO controller in front of an external two-port SRAM with one-cycle read
// latency. The word at the head of the queue is presented straight from
// ram_rd. It is held there because the RAM keeps its read data stable while
// ram_ren is low.
module tpsram_fifo_ctrl #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 5,
  parameter int DEPTH     = 32,
  parameter int AF_THRESH = 28
) (
  input  logic              CLK,
  input  logic              ARST_N,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [ADDR_W:0]   level,
  output logic              almost_full,
  output logic              overflow,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wd,
  output logic              ram_ren,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rd
);

  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   AF_C     = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] wptr, rptr;
  logic [ADDR_W:0]   ram_count;
  logic              out_valid_q, overflow_q;
  logic              push, pop, rd;

  // Handshakes. Ready depends only on the registered count, so a pop in the
  // same cycle does not free a slot until the next cycle. The read issue also
  // uses the registered count. Because of this, a read never targets the slot
  // that is being written in the same cycle. A push is masked while reset is
  // asserted.
  assign in_ready = (ram_count != DEPTH_C) & ~flush;
  assign push     = in_valid & in_ready & ARST_N;
  assign pop      = out_valid_q & out_ready;
  assign rd       = (ram_count != '0) & (~out_valid_q | pop) & ~flush;

  assign ram_wen   = push;
  assign ram_waddr = wptr;
  assign ram_wd    = in_data;
  assign ram_ren   = rd;
  assign ram_raddr = rptr;

  assign out_valid   = out_valid_q;
  assign out_data    = ram_rd;
  assign overflow    = overflow_q;
  assign level       = ram_count + {{ADDR_W{1'b0}}, out_valid_q};
  assign almost_full = (level >= AF_C);

  // Pointers, occupancy, head-valid and the sticky overflow flag.
  // Flush takes priority over every other update.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      wptr        <= '0;
      rptr        <= '0;
      ram_count   <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (flush) begin
      wptr        <= '0;
      rptr        <= '0;
      ram_count   <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (push) wptr <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
      if (rd)   rptr <= (rptr == PTR_LAST) ? '0 : rptr + 1'b1;
      case ({push, rd})
        2'b10:   ram_count <= ram_count + 1'b1;
        2'b01:   ram_count <= ram_count - 1'b1;
        default: ram_count <= ram_count;
      endcase
      if (rd)       out_valid_q <= 1'b1;
      else if (pop) out_valid_q <= 1'b0;
      if (in_valid & ~in_ready) overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tpsram_fifo_ctrl.sv
// Bench for tpsram_fifo_ctrl. A queue-based reference model predicts every
// output on every cycle. Directed scenarios add hand-computed literal
// expectations on top of the model.
module tb_tpsram_fifo_ctrl;
  localparam int DW = 16, AW = 5, D = 32, AF = 28;

  logic          CLK = 1'b0, ARST_N = 1'b0;
  logic          flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid, almost_full, overflow, ram_wen, ram_ren;
  logic [DW-1:0] out_data, ram_wd, ram_rd;
  logic [AW:0]   level;
  logic [AW-1:0] ram_waddr, ram_raddr;

  tpsram_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D), .AF_THRESH(AF)) dut (
    .CLK(CLK), .ARST_N(ARST_N), .flush(flush), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .level(level),
    .almost_full(almost_full), .overflow(overflow), .ram_wen(ram_wen),
    .ram_waddr(ram_waddr), .ram_wd(ram_wd), .ram_ren(ram_ren),
    .ram_raddr(ram_raddr), .ram_rd(ram_rd)
  );

  always #5 CLK = ~CLK;

  // External SRAM: data is registered on ram_ren and held otherwise.
  logic [DW-1:0] mem [0:D-1];
  always @(posedge CLK) begin
    if (ram_wen) mem[ram_waddr] <= ram_wd;
    if (ram_ren) ram_rd <= mem[ram_raddr];
  end

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model. It holds the words stored in the RAM as a queue, plus
  // the head word and the write/read slot counts modulo the depth.
  logic [DW-1:0] mq[$];
  bit            mvalid, movf;
  logic [DW-1:0] mhead;
  int            wcnt, rcnt;

  task automatic mclear();
    mq.delete(); mvalid = 0; movf = 0; wcnt = 0; rcnt = 0;
  endtask

  task automatic mexp(output bit e_ir, output bit e_push, output bit e_pop, output bit e_rd);
    e_ir   = (mq.size() != D) && !flush;
    e_push = in_valid && e_ir && ARST_N;
    e_pop  = mvalid && out_ready;
    e_rd   = (mq.size() != 0) && (!mvalid || e_pop) && !flush;
  endtask

  task automatic mcmp();
    bit e_ir, e_push, e_pop, e_rd;
    int lvl;
    mexp(e_ir, e_push, e_pop, e_rd);
    lvl = mq.size() + int'(mvalid);
    chk("in_ready", 32'(in_ready), 32'(e_ir));
    chk("ram_wen", 32'(ram_wen), 32'(e_push));
    if (e_push) begin
      chk("ram_waddr", 32'(ram_waddr), 32'(wcnt));
      chk("ram_wd", 32'(ram_wd), 32'(in_data));
    end
    chk("ram_ren", 32'(ram_ren), 32'(e_rd));
    if (e_rd) chk("ram_raddr", 32'(ram_raddr), 32'(rcnt));
    chk("out_valid", 32'(out_valid), 32'(mvalid));
    if (mvalid) chk("out_data", 32'(out_data), 32'(mhead));
    chk("level", 32'(level), 32'(lvl));
    chk("almost_full", 32'(almost_full), 32'(lvl >= AF));
    chk("overflow", 32'(overflow), 32'(movf));
  endtask

  task automatic mupd();
    bit e_ir, e_push, e_pop, e_rd;
    mexp(e_ir, e_push, e_pop, e_rd);
    if (!ARST_N || flush) begin
      mclear();
    end else begin
      if (in_valid && !e_ir) movf = 1;
      if (e_rd) begin mhead = mq.pop_front(); mvalid = 1; rcnt = (rcnt + 1) % D; end
      else if (e_pop) mvalid = 0;
      if (e_push) begin mq.push_back(in_data); wcnt = (wcnt + 1) % D; end
    end
  endtask

  task automatic settle(); @(negedge CLK); mcmp(); endtask
  task automatic adv(); @(posedge CLK); mupd(); #1; endtask
  task automatic tick(); settle(); adv(); endtask

  logic [DW-1:0] got[$];
  int pop_cyc[$];

  initial begin
    int acc, af_lvl, first_rej, sent, errs, lvl_bad;
    mclear();
    // Reset state
    repeat (2) begin
      settle();
      chk("rst_level", 32'(level), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_ren", 32'(ram_ren), 0);
      chk("rst_af", 32'(almost_full), 0);
      adv();
    end
    ARST_N = 1;

    // First word latency: push at cycle 0 -> read at cycle 1 -> head at cycle 2
    in_valid = 1; in_data = 16'h1234;
    settle(); chk("c0_wen", 32'(ram_wen), 1); chk("c0_waddr", 32'(ram_waddr), 0); adv();
    in_valid = 0;
    settle(); chk("c1_ren", 32'(ram_ren), 1); chk("c1_raddr", 32'(ram_raddr), 0);
    chk("c1_ov", 32'(out_valid), 0); adv();
    out_ready = 1;
    settle(); chk("c2_ov", 32'(out_valid), 1); chk("c2_data", 32'(out_data), 32'h1234); adv();
    out_ready = 0; tick();

    // Overfill: 40 pushes, no pops
    acc = 0; af_lvl = -1; first_rej = -1;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1; in_data = DW'(i);
      settle();
      if (in_ready) acc++;
      if (almost_full && af_lvl < 0) af_lvl = int'(level);
      if (first_rej >= 0 && i == first_rej + 1) chk("ovf_after_rej", 32'(overflow), 1);
      if (!in_ready && first_rej < 0) begin
        first_rej = i;
        chk("ovf_before_rej", 32'(overflow), 0);
      end
      adv();
    end
    in_valid = 0;
    settle();
    chk("fill_accepted", 32'(acc), 33);
    chk("fill_level", 32'(level), 33);
    chk("fill_in_ready", 32'(in_ready), 0);
    chk("fill_ovf", 32'(overflow), 1);
    chk("af_first_level", 32'(af_lvl), 28);
    chk("first_reject_idx", 32'(first_rej), 33);
    adv();

    // Flush while full, then a single word through
    flush = 1;
    settle(); chk("fl_wen", 32'(ram_wen), 0); chk("fl_ren", 32'(ram_ren), 0); adv();
    flush = 0; in_valid = 1; in_data = 16'hBEEF;
    settle();
    chk("fl_level", 32'(level), 0); chk("fl_ov", 32'(out_valid), 0);
    chk("fl_ovf", 32'(overflow), 0); chk("fl_in_ready", 32'(in_ready), 1);
    adv();
    in_valid = 0; tick();
    out_ready = 1;
    settle(); chk("beef_ov", 32'(out_valid), 1); chk("beef_data", 32'(out_data), 32'hBEEF); adv();
    out_ready = 0;
    settle(); chk("beef_empty", 32'(level), 0); adv();

    // Stream 100 words with push and pop both always requested
    sent = 0; got.delete(); pop_cyc.delete();
    out_ready = 1;
    for (int c = 0; c < 106; c++) begin
      in_valid = (sent < 100); in_data = DW'(sent);
      settle();
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin got.push_back(out_data); pop_cyc.push_back(c); end
      adv();
    end
    in_valid = 0; out_ready = 0;
    errs = 0;
    foreach (got[k]) if (got[k] !== DW'(k)) errs++;
    chk("stream_count", 32'(got.size()), 100);
    chk("stream_order_errs", 32'(errs), 0);
    if (got.size() == 100) begin
      chk("stream_first_pop", 32'(pop_cyc[0]), 2);
      chk("stream_last_pop", 32'(pop_cyc[99]), 101);
    end

    // Refill to full, then push and pop together for 10 cycles
    for (int i = 0; i < 33; i++) begin in_valid = 1; in_data = DW'(100 + i); tick(); end
    in_valid = 0;
    settle(); chk("full2_level", 32'(level), 33); adv();
    got.delete(); lvl_bad = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1; out_ready = 1; in_data = DW'(200 + c);
      settle();
      if (level < 32 || level > 33) lvl_bad++;
      if (c > 0) chk("ready_after_pop", 32'(in_ready), 1);
      if (out_valid && out_ready) got.push_back(out_data);
      adv();
    end
    in_valid = 0;
    errs = 0;
    foreach (got[k]) if (got[k] !== DW'(100 + k)) errs++;
    chk("fullpp_pops", 32'(got.size()), 10);
    chk("fullpp_order_errs", 32'(errs), 0);
    chk("fullpp_level_range", 32'(lvl_bad), 0);
    repeat (40) tick();
    out_ready = 0;
    settle(); chk("drain_level", 32'(level), 0); adv();

    // Random traffic with occasional flush; the model checks every cycle
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = DW'($urandom);
      flush     = ($urandom_range(0, 60) == 0);
      tick();
    end
    flush = 0;

    // Async reset in the middle of traffic
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin in_valid = 1; in_data = DW'($urandom); tick(); end
    in_valid = 0;
    settle(); chk("pre_rst_ov", 32'(out_valid), 1); adv();
    #2 ARST_N = 0;
    #1;
    chk("arst_ov", 32'(out_valid), 0);
    chk("arst_level", 32'(level), 0);
    chk("arst_ren", 32'(ram_ren), 0);
    mclear();
    repeat (2) tick();
    ARST_N = 1;
    in_valid = 1; in_data = 16'hA5A5;
    settle(); chk("post_rst_wen", 32'(ram_wen), 1); adv();
    in_valid = 0;
    settle(); chk("post_rst_c1_ov", 32'(out_valid), 0); adv();
    out_ready = 1;
    settle(); chk("post_rst_ov", 32'(out_valid), 1); chk("post_rst_data", 32'(out_data), 32'hA5A5); adv();
    out_ready = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
